// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle between a register-file driver and the
// bit-serial adder controller.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START,
        output A,
        output B,
        output CIN,
        input  SUM,
        input  COUT,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  START,
        input  A,
        input  B,
        input  CIN,
        output SUM,
        output COUT,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder (two half adders plus an OR) is reused
// across all WIDTH bit positions, LSB first, one bit per clock.
module Half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             ha1_s, ha1_c, fa_sum, ha2_c, fa_cout;
    logic [WIDTH-1:0] opa_shr, opb_shr, acc_shr;

    // Shared full adder
    Half_adder u_ha1 (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .s_o (ha1_s),
        .c_o (ha1_c)
    );

    Half_adder u_ha2 (
        .a_i (ha1_s),
        .b_i (carry_q),
        .s_o (fa_sum),
        .c_o (ha2_c)
    );

    assign fa_cout = ha1_c | ha2_c;

    // Operands drain towards bit 0; the new sum bit enters at the MSB so that
    // after WIDTH shifts bit 0 of the result has reached position 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign opa_shr[gi] = opa_q[gi+1];
            assign opb_shr[gi] = opb_q[gi+1];
            assign acc_shr[gi] = acc_q[gi+1];
        end
    endgenerate

    assign opa_shr[WIDTH-1] = 1'b0;
    assign opb_shr[WIDTH-1] = 1'b0;
    assign acc_shr[WIDTH-1] = fa_sum;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    opa_d   = bus.A;
                    opb_d   = bus.B;
                    carry_d = bus.CIN;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                opa_d   = opa_shr;
                opb_d   = opb_shr;
                acc_d   = acc_shr;
                carry_d = fa_cout;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the result; the counter is left alone
                    // so it never wraps inside an operation.
                    sum_d   = acc_shr;
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.BUSY = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table, throughput with START
// held high, asynchronous mid-run reset, and a reduced operand sweep.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] es, input logic ec);
        logic busy_ok, hold_ok;
        bus.START = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.CIN   = cin;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.CIN   = ~cin;
        busy_ok   = 1'b1;
        hold_ok   = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (!(bus.BUSY === 1'b1 && bus.DONE === 1'b0)) busy_ok = 1'b0;
            if (bus.SUM !== last_sum || bus.COUT !== last_cout) hold_ok = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
        end
        chk({tag, ".busy_run"}, 32'(busy_ok), 32'd1);
        chk({tag, ".sum_hold"}, 32'(hold_ok), 32'd1);
        chk({tag, ".done"}, 32'(bus.DONE), 32'd1);
        chk({tag, ".busy_done"}, 32'(bus.BUSY), 32'd1);
        chk({tag, ".sum"}, 32'(bus.SUM), 32'(es));
        chk({tag, ".cout"}, 32'(bus.COUT), 32'(ec));
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ".done_fall"}, 32'(bus.DONE), 32'd0);
        chk({tag, ".busy_fall"}, 32'(bus.BUSY), 32'd0);
        chk({tag, ".sum_keep"}, 32'(bus.SUM), 32'(es));
        last_sum  = es;
        last_cout = ec;
        $display("op %s: A=%02h B=%02h CIN=%0d -> SUM=%02h COUT=%0d", tag, a, b, cin, bus.SUM, bus.COUT);
    endtask

    function automatic logic [W-1:0] f_a(input int n);
        return W'((n * 37 + 5) % 256);
    endfunction

    function automatic logic [W-1:0] f_b(input int n);
        return W'((n * 91 + 200) % 256);
    endfunction

    initial begin
        logic [W:0] t;
        logic       no_done;
        logic       stop;

        vecs[0] = '{"zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{"3c_0f",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[2] = '{"ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{"a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{"7f_01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{"80_80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{"ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{"12_34_c", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.CIN   = 1'b0;

        #1 RST = 1'b1;
        #1;
        chk("rst.sum",  32'(bus.SUM),  32'd0);
        chk("rst.cout", 32'(bus.COUT), 32'd0);
        chk("rst.busy", 32'(bus.BUSY), 32'd0);
        chk("rst.done", 32'(bus.DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);

        // START held high with operands changing every cycle
        for (int n = 0; n < 30; n++) begin
            bus.START = 1'b1;
            bus.A     = f_a(n);
            bus.B     = f_b(n);
            bus.CIN   = n[0];
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("thru.done[%0d]", n), 32'(bus.DONE), 32'((n % 10) == 8));
            chk($sformatf("thru.busy[%0d]", n), 32'(bus.BUSY), 32'((n % 10) != 9));
            if ((n % 10) == 8) begin
                t = {1'b0, f_a(n - 8)} + {1'b0, f_b(n - 8)} + (W+1)'((n - 8) & 1);
                chk($sformatf("thru.sum[%0d]", n), 32'(bus.SUM), 32'(t[W-1:0]));
                chk($sformatf("thru.cout[%0d]", n), 32'(bus.COUT), 32'(t[W]));
                last_sum  = t[W-1:0];
                last_cout = t[W];
                $display("thru result at cycle %0d: SUM=%02h COUT=%0d", n, bus.SUM, bus.COUT);
            end
        end
        bus.START = 1'b0;
        @(negedge CLK);

        // Asynchronous reset while bit 4 of 7F+01 is pending
        bus.START = 1'b1;
        bus.A     = 8'h7F;
        bus.B     = 8'h01;
        bus.CIN   = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst.sum",  32'(bus.SUM),  32'd0);
        chk("arst.cout", 32'(bus.COUT), 32'd0);
        chk("arst.busy", 32'(bus.BUSY), 32'd0);
        chk("arst.done", 32'(bus.DONE), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) no_done = 1'b0;
        end
        chk("arst.no_done", 32'(no_done), 32'd1);
        $display("async reset mid-run: SUM=%02h BUSY=%0d", bus.SUM, bus.BUSY);
        last_sum  = '0;
        last_cout = 1'b0;
        run_op("post_rst", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // Reduced sweep against the reference A+B+CIN, stopping on first error
        stop = 1'b0;
        for (int i = 0; i < 16 && !stop; i++) begin
            for (int j = 0; j < 16 && !stop; j++) begin
                for (int c = 0; c < 2 && !stop; c++) begin
                    logic [W-1:0] sa, sb;
                    int           e0;
                    sa = W'(i * 17);
                    sb = W'((j * 17) ^ 8'h5A);
                    t  = {1'b0, sa} + {1'b0, sb} + (W+1)'(c);
                    e0 = errors;
                    run_op("sweep", sa, sb, c[0], t[W-1:0], t[W]);
                    if (errors != e0) stop = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
